// File: rtl/vga_pkg.sv
// vga_pkg: timing constants, vertical FSM state type and colour codes for the VGA
// colour datapath. Also has a small window-decode helper.
package vga_pkg;

    // 640x480 @ 60 Hz from a 50 MHz system clock
    localparam int unsigned VGA_CLK_DIV         = 2;
    localparam int unsigned VGA_H_SYNC          = 96;
    localparam int unsigned VGA_H_BP            = 48;
    localparam int unsigned VGA_H_ACTIVE        = 640;
    localparam int unsigned VGA_H_FP            = 16;
    localparam int unsigned VGA_V_SYNC          = 2;
    localparam int unsigned VGA_V_BP            = 33;
    localparam int unsigned VGA_V_ACTIVE        = 480;
    localparam int unsigned VGA_V_FP            = 10;
    localparam int unsigned VGA_FRAMES_PER_STEP = 60;

    localparam int unsigned VGA_H_TOTAL = VGA_H_SYNC + VGA_H_BP + VGA_H_ACTIVE + VGA_H_FP;
    localparam int unsigned VGA_V_TOTAL = VGA_V_SYNC + VGA_V_BP + VGA_V_ACTIVE + VGA_V_FP;

    // Raster counters are 10 bits, so each total must stay <= 1024
    localparam int unsigned CNT_W = 10;

    typedef enum logic [1:0] {
        V_SYNC_S,
        V_BACK_S,
        V_ACT_S,
        V_FRONT_S
    } vstate_e;

    // Colour codes understood by the bit generator's switches input
    typedef enum logic [2:0] {
        RED      = 3'b000,
        GREEN    = 3'b001,
        BLUE     = 3'b010,
        YELLOW   = 3'b011,
        BABYBLUE = 3'b100,
        PINK     = 3'b101,
        WHITE    = 3'b110
    } color_e;

    // True when lo <= pos < hi (unsigned)
    function automatic logic in_window(input logic [CNT_W-1:0] pos,
                                       input int unsigned lo,
                                       input int unsigned hi);
        return (32'(pos) >= lo) && (32'(pos) < hi);
    endfunction

endpackage

// File: rtl/vga_timing_ctrl_if.sv
// vga_timing_ctrl_if: bundles the timing controller's board inputs and raster outputs.
//   switches      raw board switches (asynchronous)
//   auto_mode     auto colour-cycle request
//   pix_en        one-clk strobe per pixel
//   hcount/vcount raster position
//   hsync/vsync   active-low syncs
//   display_pixel visible-window flag
//   frame_start   one-clk strobe at raster origin
//   color_sel     colour code to the bit generator
// master: the timing controller. slave: the consumer / board side.
interface vga_timing_ctrl_if;
    import vga_pkg::*;

    logic [2:0]       switches;
    logic             auto_mode;
    logic             pix_en;
    logic [CNT_W-1:0] hcount;
    logic [CNT_W-1:0] vcount;
    logic             hsync;
    logic             vsync;
    logic             display_pixel;
    logic             frame_start;
    logic [2:0]       color_sel;

    modport master (
        input  switches, auto_mode,
        output pix_en, hcount, vcount, hsync, vsync, display_pixel, frame_start, color_sel
    );

    modport slave (
        output switches, auto_mode,
        input  pix_en, hcount, vcount, hsync, vsync, display_pixel, frame_start, color_sel
    );

endinterface

// File: rtl/vga_sync_2ff.sv
// vga_sync_2ff: two-flop synchroniser for slow asynchronous level inputs.
//   clk  system clock
//   rst  asynchronous reset, active-high (outputs clear to 0)
//   d    asynchronous input, WIDTH bits
//   q    synchronised output, two clks of latency
module vga_sync_2ff #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/vga_timing_ctrl.sv
// vga_timing_ctrl: VGA raster sequencer and frame-synchronous colour-select register.
//   clk  system clock (50 MHz for the default timing)
//   rst  asynchronous reset, active-high
//   bus  vga_timing_ctrl_if.master: switches/auto_mode in; pix_en, hcount, vcount, hsync,
//        vsync, display_pixel, frame_start, color_sel out
// All raster outputs are registered and decoded from the next-count values, so they change
// together on the clk that pix_en is high.
// Build option: define VGA_AUTOCYCLE_EN to enable auto colour cycling driven by auto_mode;
// otherwise auto_mode is ignored and color_sel follows the switches at each frame start.
module vga_timing_ctrl
    import vga_pkg::*;
#(
    parameter int unsigned CLK_DIV         = VGA_CLK_DIV,
    parameter int unsigned H_SYNC          = VGA_H_SYNC,
    parameter int unsigned H_BP            = VGA_H_BP,
    parameter int unsigned H_ACTIVE        = VGA_H_ACTIVE,
    parameter int unsigned H_FP            = VGA_H_FP,
    parameter int unsigned V_SYNC          = VGA_V_SYNC,
    parameter int unsigned V_BP            = VGA_V_BP,
    parameter int unsigned V_ACTIVE        = VGA_V_ACTIVE,
    parameter int unsigned V_FP            = VGA_V_FP,
    parameter int unsigned FRAMES_PER_STEP = VGA_FRAMES_PER_STEP
) (
    input  logic             clk,
    input  logic             rst,
    vga_timing_ctrl_if.master bus
);

    localparam int unsigned H_TOTAL    = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int unsigned V_TOTAL    = V_SYNC + V_BP + V_ACTIVE + V_FP;
    localparam int unsigned H_ACT_LO   = H_SYNC + H_BP;
    localparam int unsigned H_ACT_HI   = H_ACT_LO + H_ACTIVE;
    localparam int unsigned V_ACT_LO   = V_SYNC + V_BP;
    localparam int unsigned V_FRONT_LO = V_ACT_LO + V_ACTIVE;
    localparam int unsigned DIV_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    // Pixel-clock divider
    logic [DIV_W-1:0] div_q, div_d;
    logic             tick;

    // Raster counters
    logic [CNT_W-1:0] h_q, h_d;
    logic [CNT_W-1:0] v_q, v_d;
    logic             h_wrap, v_wrap;

    vstate_e vstate_q, vstate_d;

    // Registered outputs
    logic pix_en_q;
    logic hsync_q, hsync_d;
    logic vsync_q, vsync_d;
    logic disp_q, disp_d;
    logic fs_q, fs_d;
    logic [2:0] color_q, color_d;

    logic [2:0] sw_sync;

    vga_sync_2ff #(
        .WIDTH(3)
    ) u_sync_sw (
        .clk(clk),
        .rst(rst),
        .d  (bus.switches),
        .q  (sw_sync)
    );

    // The divider's last count is the clk on which every raster register advances
    assign tick  = (div_q == DIV_W'(CLK_DIV - 1));
    assign div_d = tick ? '0 : div_q + 1'b1;

    assign h_wrap = (h_q == CNT_W'(H_TOTAL - 1));
    assign v_wrap = (v_q == CNT_W'(V_TOTAL - 1));

    always_comb begin
        h_d = h_q;
        v_d = v_q;
        if (tick) begin
            if (h_wrap) begin
                h_d = '0;
                v_d = v_wrap ? '0 : v_q + 1'b1;
            end else begin
                h_d = h_q + 1'b1;
            end
        end
    end

    // Only the wrap back to the origin raises frame_start, never the post-reset (0,0)
    assign fs_d = tick & h_wrap & v_wrap;

    // Vertical FSM: moves only on a line wrap, keyed on the line being entered
    always_comb begin
        vstate_d = vstate_q;
        if (tick && h_wrap) begin
            case (vstate_q)
                V_SYNC_S:  if (v_d == CNT_W'(V_SYNC))     vstate_d = V_BACK_S;
                V_BACK_S:  if (v_d == CNT_W'(V_ACT_LO))   vstate_d = V_ACT_S;
                V_ACT_S:   if (v_d == CNT_W'(V_FRONT_LO)) vstate_d = V_FRONT_S;
                V_FRONT_S: if (v_d == '0)                 vstate_d = V_SYNC_S;
                default:                                  vstate_d = V_SYNC_S;
            endcase
        end
    end

    // Decode from next-state values so syncs line up with the counters
    always_comb begin
        hsync_d = (32'(h_d) >= H_SYNC);
        vsync_d = (vstate_d != V_SYNC_S);
        disp_d  = (vstate_d == V_ACT_S) && in_window(h_d, H_ACT_LO, H_ACT_HI);
    end

`ifdef VGA_AUTOCYCLE_EN
    localparam int unsigned FC_W = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;

    logic            auto_sync;
    logic [FC_W-1:0] fc_q, fc_d;

    vga_sync_2ff #(
        .WIDTH(1)
    ) u_sync_auto (
        .clk(clk),
        .rst(rst),
        .d  (bus.auto_mode),
        .q  (auto_sync)
    );

    always_comb begin
        color_d = color_q;
        fc_d    = fc_q;
        if (fs_d) begin
            if (auto_sync) begin
                if (fc_q == FC_W'(FRAMES_PER_STEP - 1)) begin
                    fc_d    = '0;
                    color_d = color_q + 3'd1;  // 7 rolls over to 0
                end else begin
                    fc_d = fc_q + 1'b1;
                end
            end else begin
                fc_d    = '0;
                color_d = sw_sync;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fc_q <= '0;
        end else begin
            fc_q <= fc_d;
        end
    end
`else
    logic unused_auto;
    assign unused_auto = bus.auto_mode;

    always_comb begin
        color_d = color_q;
        if (fs_d) begin
            color_d = sw_sync;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q    <= '0;
            h_q      <= '0;
            v_q      <= '0;
            vstate_q <= V_SYNC_S;
            pix_en_q <= 1'b0;
            hsync_q  <= 1'b0;
            vsync_q  <= 1'b0;
            disp_q   <= 1'b0;
            fs_q     <= 1'b0;
            color_q  <= RED;
        end else begin
            div_q    <= div_d;
            h_q      <= h_d;
            v_q      <= v_d;
            vstate_q <= vstate_d;
            pix_en_q <= tick;
            hsync_q  <= hsync_d;
            vsync_q  <= vsync_d;
            disp_q   <= disp_d;
            fs_q     <= fs_d;
            color_q  <= color_d;
        end
    end

    assign bus.pix_en        = pix_en_q;
    assign bus.hcount        = h_q;
    assign bus.vcount        = v_q;
    assign bus.hsync         = hsync_q;
    assign bus.vsync         = vsync_q;
    assign bus.display_pixel = disp_q;
    assign bus.frame_start   = fs_q;
    assign bus.color_sel     = color_q;

endmodule
